// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package display_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/display_mux_ctrl_slot_timer.sv
// Free-running slot prescaler: counts while en, clears to 0 on clear,
// wrap flags the terminal count of each slot.
module slot_timer #(
  parameter int unsigned DIV_BITS = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  output logic [DIV_BITS-1:0] cnt,
  output logic                wrap
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == '1);

endmodule

// File: rtl/display_mux_ctrl.sv
// Round-robin scan controller sharing one seven-segment decoder between
// NUM_DIGITS common-anode digits, with per-slot blanking and frame-latched digits.
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DIV_BITS     = 17,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              hex_sel,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_start
);

  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS ||
      64'(BLANK_CYCLES) >= (64'(1) << DIV_BITS)) begin : g_param_check
    $error("display_mux_ctrl: illegal NUM_DIGITS or BLANK_CYCLES >= 2**DIV_BITS");
  end

  logic [DIV_BITS-1:0] cnt;
  logic                wrap;

  logic [SLOT_W-1:0] slot_q, slot_d;
  nibble_t           shadow_q [NUM_DIGITS];
  nibble_t           shadow_d [NUM_DIGITS];
  nibble_t           digits_unpk [NUM_DIGITS];
  logic              enable_q;
  logic              frame_start_q, frame_start_d;
  logic              drive;

  slot_timer #(.DIV_BITS(DIV_BITS)) u_slot_timer (
    .clk   (clk),
    .reset (reset),
    .clear (~enable),
    .en    (enable),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_unpk[i] = digits_in[NIBBLE_W*i +: NIBBLE_W];
    end
  end

  // Parked scheduler tracks digits_in live; while scanning, digits only reload at frame wrap.
  always_comb begin
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    frame_start_d = 1'b0;
    if (!enable) begin
      slot_d   = '0;
      shadow_d = digits_unpk;
    end else if (wrap) begin
      if (slot_q == LAST_SLOT) begin
        slot_d        = '0;
        shadow_d      = digits_unpk;
        frame_start_d = 1'b1;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q        <= '0;
      shadow_q      <= '{default: '0};
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      enable_q      <= enable;
      frame_start_q <= frame_start_d;
    end
  end

  // Pin decode uses registered state only; the blank window keeps anodes exclusive.
  always_comb begin
    drive   = enable_q && (cnt >= DIV_BITS'(BLANK_CYCLES));
    anode_n = ANODE_OFF[NUM_DIGITS-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (drive && slot_q == SLOT_W'(i)) begin
        anode_n[i] = 1'b0;
      end
    end
  end

  assign hex_sel     = shadow_q[slot_q];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl: small fast instance for scan/latch/enable/reset
// sequences, larger-prescaler instance for blank boundary, slot timing and exclusivity.
module tb_display_mux_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic [7:0] digits_in;
  logic [3:0] hex_sel;
  logic [1:0] anode_n;
  logic       frame_start;

  logic       reset_b, enable_b;
  logic [7:0] digits_b;
  logic [3:0] hex_b;
  logic [1:0] anode_b;
  logic       fs_b;

  int n_checks = 0;
  int n_pass   = 0;

  display_mux_ctrl #(.NUM_DIGITS(2), .DIV_BITS(4), .BLANK_CYCLES(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .digits_in   (digits_in),
    .hex_sel     (hex_sel),
    .anode_n     (anode_n),
    .frame_start (frame_start)
  );

  display_mux_ctrl #(.NUM_DIGITS(2), .DIV_BITS(12), .BLANK_CYCLES(64)) u_big (
    .clk         (clk),
    .reset       (reset_b),
    .enable      (enable_b),
    .digits_in   (digits_b),
    .hex_sel     (hex_b),
    .anode_n     (anode_b),
    .frame_start (fs_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // At most one anode may be driven on either instance in any cycle.
  always @(negedge clk) begin
    chk("onehot_main", 32'($countones(~anode_n) <= 1), 32'd1);
    chk("onehot_big",  32'($countones(~anode_b) <= 1), 32'd1);
  end

  typedef struct {
    int         lo;
    int         hi;
    logic       en;
    logic [7:0] dig;
    logic [1:0] an;
    logic [3:0] hex;
    logic       fs;
  } win_t;

  win_t tbl[$];

  initial begin
    tbl.push_back('{0,   1,   1'b1, 8'h3A, 2'b11, 4'hA, 1'b0});
    tbl.push_back('{2,   15,  1'b1, 8'h3A, 2'b10, 4'hA, 1'b0});
    tbl.push_back('{16,  17,  1'b1, 8'h3A, 2'b11, 4'h3, 1'b0});
    tbl.push_back('{18,  19,  1'b1, 8'h3A, 2'b01, 4'h3, 1'b0});
    tbl.push_back('{20,  31,  1'b1, 8'h5C, 2'b01, 4'h3, 1'b0});
    tbl.push_back('{32,  32,  1'b1, 8'h5C, 2'b11, 4'hC, 1'b1});
    tbl.push_back('{33,  33,  1'b1, 8'h5C, 2'b11, 4'hC, 1'b0});
    tbl.push_back('{34,  47,  1'b1, 8'h5C, 2'b10, 4'hC, 1'b0});
    tbl.push_back('{48,  49,  1'b1, 8'h5C, 2'b11, 4'h5, 1'b0});
    tbl.push_back('{50,  63,  1'b1, 8'h5C, 2'b01, 4'h5, 1'b0});
    tbl.push_back('{64,  64,  1'b1, 8'h5C, 2'b11, 4'hC, 1'b1});
    tbl.push_back('{65,  65,  1'b1, 8'h5C, 2'b11, 4'hC, 1'b0});
    tbl.push_back('{66,  73,  1'b1, 8'h5C, 2'b10, 4'hC, 1'b0});
    tbl.push_back('{74,  74,  1'b0, 8'h5C, 2'b10, 4'hC, 1'b0});
    tbl.push_back('{75,  75,  1'b0, 8'hE1, 2'b11, 4'hC, 1'b0});
    tbl.push_back('{76,  76,  1'b0, 8'hE1, 2'b11, 4'h1, 1'b0});
    tbl.push_back('{77,  78,  1'b1, 8'hE1, 2'b11, 4'h1, 1'b0});
    tbl.push_back('{79,  92,  1'b1, 8'hE1, 2'b10, 4'h1, 1'b0});
    tbl.push_back('{93,  94,  1'b1, 8'hE1, 2'b11, 4'hE, 1'b0});
    tbl.push_back('{95,  108, 1'b1, 8'hE1, 2'b01, 4'hE, 1'b0});
    tbl.push_back('{109, 109, 1'b1, 8'hE1, 2'b11, 4'h1, 1'b1});

    reset     = 1'b1;
    enable    = 1'b1;
    digits_in = 8'h3A;
    reset_b   = 1'b1;
    enable_b  = 1'b0;
    digits_b  = 8'h96;

    // Reset held with enable high: dark, zero nibble, no pulse.
    repeat (3) step();
    chk("rst anode", 32'(anode_n), 32'h3);
    chk("rst hex",   32'(hex_sel), 32'h0);
    chk("rst fs",    32'(frame_start), 32'h0);

    // One parked cycle loads the shadow, then scanning starts at cycle 0.
    enable = 1'b0;
    reset  = 1'b0;
    chk("rel hex", 32'(hex_sel), 32'h0);
    step();

    foreach (tbl[r]) begin
      for (int c = tbl[r].lo; c <= tbl[r].hi; c++) begin
        chk($sformatf("c%0d anode", c), 32'(anode_n),     32'(tbl[r].an));
        chk($sformatf("c%0d hex", c),   32'(hex_sel),     32'(tbl[r].hex));
        chk($sformatf("c%0d fs", c),    32'(frame_start), 32'(tbl[r].fs));
        enable    = tbl[r].en;
        digits_in = tbl[r].dig;
        step();
      end
    end

    // Cycle 110 now; advance into slot 1 drive phase then hit reset mid-cycle.
    repeat (20) step();
    chk("c130 anode", 32'(anode_n), 32'h1);
    chk("c130 hex",   32'(hex_sel), 32'hE);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst anode", 32'(anode_n), 32'h3);
    chk("async rst hex",   32'(hex_sel), 32'h0);
    chk("async rst fs",    32'(frame_start), 32'h0);
    repeat (3) step();
    chk("rst hold anode", 32'(anode_n), 32'h3);
    reset = 1'b0;
    chk("restart c0 anode", 32'(anode_n), 32'h3);
    step();
    chk("restart c1 anode", 32'(anode_n), 32'h3);
    step();
    chk("restart c2 anode", 32'(anode_n), 32'h2);
    chk("restart c2 hex",   32'(hex_sel), 32'h0);

    // Larger prescaler: blank boundary, slot length, frame pulse over 4 frames.
    reset_b = 1'b0;
    step();
    enable_b = 1'b1;
    for (int k = 0; k < 4 * 8192; k++) begin
      if (k == 63)   chk("big c63 anode",   32'(anode_b), 32'h3);
      if (k == 64) begin
        chk("big c64 anode", 32'(anode_b), 32'h2);
        chk("big c64 hex",   32'(hex_b),   32'h6);
      end
      if (k == 4095) chk("big c4095 anode", 32'(anode_b), 32'h2);
      if (k == 4096) begin
        chk("big c4096 anode", 32'(anode_b), 32'h3);
        chk("big c4096 hex",   32'(hex_b),   32'h9);
      end
      if (k == 4160) chk("big c4160 anode", 32'(anode_b), 32'h1);
      if (k == 8191) chk("big c8191 fs",    32'(fs_b),    32'h0);
      if (k == 8192) begin
        chk("big c8192 fs",  32'(fs_b),  32'h1);
        chk("big c8192 hex", 32'(hex_b), 32'h6);
      end
      if (k == 8193) chk("big c8193 fs",    32'(fs_b),    32'h0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
